// File: rtl/alu_accumulator_pkg.sv
// Shared opcode encodings, flag bit positions and ALU operation type
// for the accumulator execute stage.
package alu_accumulator_pkg;

    // Positions inside Flags = {ZERO, CARRY, NEG, OV}
    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_OV    = 0;

    // IR[2] selects the operand: 0 -> MBR (x-form), 1 -> IBR (i-form)
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_LOAD_X  = 8'h01;
    localparam logic [7:0] OP_STORE_X = 8'h02;
    localparam logic [7:0] OP_LOAD_I  = 8'h05;
    localparam logic [7:0] OP_STORE_I = 8'h06;
    localparam logic [7:0] OP_JMP     = 8'h10;
    localparam logic [7:0] OP_JZ      = 8'h11;
    localparam logic [7:0] OP_JC      = 8'h12;

    localparam logic [7:0] OP_ADD_X   = 8'h40;
    localparam logic [7:0] OP_SUB_X   = 8'h41;
    localparam logic [7:0] OP_ADDC_X  = 8'h42;
    localparam logic [7:0] OP_SUBC_X  = 8'h43;
    localparam logic [7:0] OP_ADD_I   = 8'h44;
    localparam logic [7:0] OP_SUB_I   = 8'h45;
    localparam logic [7:0] OP_ADDC_I  = 8'h46;
    localparam logic [7:0] OP_SUBC_I  = 8'h47;

    localparam logic [7:0] OP_NOR_X   = 8'h80;
    localparam logic [7:0] OP_NAND_X  = 8'h81;
    localparam logic [7:0] OP_XOR_X   = 8'h82;
    localparam logic [7:0] OP_XNOR_X  = 8'h83;
    localparam logic [7:0] OP_NOR_I   = 8'h84;
    localparam logic [7:0] OP_NAND_I  = 8'h85;
    localparam logic [7:0] OP_XOR_I   = 8'h86;
    localparam logic [7:0] OP_XNOR_I  = 8'h87;

    // MSB picks logic vs arithmetic, low bits copy IR[1:0]
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_ADDC = 3'b010,
        ALU_SUBC = 3'b011,
        ALU_NOR  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_XNOR = 3'b111
    } alu_op_e;

    function automatic logic is_arith_op(input logic [7:0] op);
        return op[7:3] == 5'b01000;
    endfunction

    function automatic logic is_logic_op(input logic [7:0] op);
        return op[7:3] == 5'b10000;
    endfunction

endpackage

// File: rtl/alu_accumulator_core.sv
// Combinational ALU: (a, b, c_in, op) -> (r, c, v). Logic ops report c = v = 0
// so the caller can load them unconditionally into the carry/overflow flags.
module alu_accumulator_core
    import alu_accumulator_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  alu_op_e      op,
    output logic [W-1:0] r,
    output logic         c,
    output logic         v
);

    logic         invert_b;
    logic         carry_in;
    logic [W-1:0] b_eff;
    logic [W:0]   sum;

    always_comb begin
        invert_b = (op == ALU_SUB) || (op == ALU_SUBC);
        carry_in = (op == ALU_SUB) ? 1'b1 :
                   ((op == ALU_ADDC) || (op == ALU_SUBC)) ? c_in : 1'b0;
        b_eff    = invert_b ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, carry_in};

        r = sum[W-1:0];
        c = 1'b0;
        v = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_ADDC, ALU_SUBC: begin
                r = sum[W-1:0];
                c = sum[W];
                v = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
            end
            ALU_NOR:  r = ~(a | b);
            ALU_NAND: r = ~(a & b);
            ALU_XOR:  r = a ^ b;
            ALU_XNOR: r = ~(a ^ b);
            default:  r = sum[W-1:0];
        endcase
    end

endmodule

// File: rtl/alu_accumulator.sv
// Execute stage: owns the accumulator AR and {ZERO,CARRY,NEG,OV} flags and
// commits the operation in IR on each Exec strobe.
module alu_accumulator
    import alu_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  Exec,
    input  logic [INST_WIDTH-1:0] IR,
    input  logic [DATA_WIDTH-1:0] IBR,
    input  logic [DATA_WIDTH-1:0] MBR,
    output logic [DATA_WIDTH-1:0] AR,
    output logic [3:0]            Flags
);

    // Exec is a single-cycle strobe with no handshake: the operation in IR is
    // committed on the rising edge where Exec=1; Exec=0 leaves AR/Flags frozen.

    logic [7:0]            opcode;
    logic                  is_arith;
    logic                  is_logic;
    logic                  is_load;
    logic                  upd_zn;
    logic                  upd_cv;
    logic [DATA_WIDTH-1:0] operand_b;
    alu_op_e               core_op;
    logic [DATA_WIDTH-1:0] core_r;
    logic                  core_c;
    logic                  core_v;
    logic [DATA_WIDTH-1:0] result;

    always_comb begin
        opcode    = IR[7:0];
        is_arith  = is_arith_op(opcode);
        is_logic  = is_logic_op(opcode);
        is_load   = (opcode == OP_LOAD_X) || (opcode == OP_LOAD_I);
        upd_zn    = is_arith || is_logic || is_load;
        upd_cv    = is_arith || is_logic;
        operand_b = opcode[2] ? IBR : MBR;
        core_op   = alu_op_e'({is_logic, opcode[1:0]});
        result    = is_load ? operand_b : core_r;
    end

    alu_accumulator_core #(
        .W (DATA_WIDTH)
    ) u_core (
        .a    (AR),
        .b    (operand_b),
        .c_in (Flags[FLAG_CARRY]),
        .op   (core_op),
        .r    (core_r),
        .c    (core_c),
        .v    (core_v)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            AR    <= '0;
            Flags <= 4'b0000;
        end else if (Exec) begin
            if (upd_zn) begin
                AR               <= result;
                Flags[FLAG_ZERO] <= (result == '0);
                Flags[FLAG_NEG]  <= result[DATA_WIDTH-1];
            end
            if (upd_cv) begin
                Flags[FLAG_CARRY] <= core_c;
                Flags[FLAG_OV]    <= core_v;
            end
        end
    end

endmodule
